data_mem_responder: RTL and testbench

Data-memory responder: the memory-side end of the core's d_m_* load/store interface.
- Accepts read/write requests from the core's mem stage.
- Serves them from an internal word-addressed RAM after a configurable number of wait states.
- Returns rdata plus a single-cycle hit pulse.
- Used as the non-perfect data memory in the SoC and in simulation, exercising the core's mem_ready stall path.

---
 rtl/core_pkg.sv | 11 +
 rtl/data_mem_responder_pkg.sv | 26 ++
 rtl/data_mem_responder_ram.sv | 41 ++++
 rtl/data_mem_responder.sv | 150 +++++++++++++++
 tb/tb_data_mem_responder.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Core-wide bus widths shared by the memory-side blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
endpackage
`default_nettype wire

// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder_pkg
// Description : Types and helpers for the data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package data_mem_responder_pkg;
  import core_pkg::*;

  localparam int c_byte_w = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Byte offset bits below the word boundary are discarded.
  function automatic logic [ADDR_WIDTH-1:0] word_index(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [ADDR_WIDTH-1:0] base
  );
    return (addr - base) >> $clog2(c_byte_w);
  endfunction
endpackage
`default_nettype wire

// File: rtl/data_mem_responder_ram.sv
`default_nettype none
// ============================================================================
// Module      : byte_mask_ram
// Description : Single-port RAM, per-byte write enable, registered read.
// Revision    : 1.0 - initial release
// ============================================================================
module byte_mask_ram #(
  parameter int DEPTH      = 1024,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          i_en,
  input  logic                          i_we,
  input  logic [DATA_WIDTH/8-1:0]       i_wmask,
  input  logic [$clog2(DEPTH)-1:0]      i_idx,
  input  logic [DATA_WIDTH-1:0]         i_wdata,
  output logic [DATA_WIDTH-1:0]         o_rdata
);
  localparam int c_byte_w = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata;

  // No reset so FPGA flows can map this onto block RAM.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        for (int b = 0; b < c_byte_w; b++) begin
          if (i_wmask[b]) begin
            r_mem[i_idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
          end
        end
      end else begin
        r_rdata <= r_mem[i_idx];
      end
    end
  end

  assign o_rdata = r_rdata;
endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Wait-stated data-memory slave for the core's d_m_* port.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
  import core_pkg::*;
  import data_mem_responder_pkg::*;
#(
  parameter int                    DEPTH        = 1024,
  parameter int                    WAIT_STATES  = 2,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS = '0
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [ADDR_WIDTH-1:0] d_m_addr_i,
  input  logic                  d_m_rden_i,
  input  logic                  d_m_wren_i,
  input  logic [c_byte_w-1:0]   d_m_wmask_i,
  input  logic [DATA_WIDTH-1:0] d_m_wdata_i,
  output logic [DATA_WIDTH-1:0] d_m_rdata_o,
  output logic                  d_m_hit_o,
  output logic                  oor_o
);
  localparam int         c_idx_w    = $clog2(DEPTH);
  localparam logic [3:0] c_cnt_load = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [c_idx_w-1:0]    r_idx;
  logic                  r_in_range;
  logic                  r_write;
  logic                  r_both;
  logic [c_byte_w-1:0]   r_wmask;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_hit;
  logic                  r_oor;
  logic                  r_from_ram;

  logic                  w_req;
  logic [ADDR_WIDTH-1:0] w_live_idx;
  logic                  w_live_in_range;
  logic [c_idx_w-1:0]    w_acc_idx;
  logic                  w_acc_in_range;
  logic                  w_acc_write;
  logic                  w_acc_both;
  logic [c_byte_w-1:0]   w_acc_wmask;
  logic [DATA_WIDTH-1:0] w_acc_wdata;
  logic                  w_go_resp;
  logic                  w_ram_en;
  logic [DATA_WIDTH-1:0] w_ram_rdata;

  // With zero wait states the access completes straight from the live inputs.
  always_comb begin
    w_req           = d_m_rden_i | d_m_wren_i;
    w_live_idx      = word_index(d_m_addr_i, BASE_ADDRESS);
    w_live_in_range = (d_m_addr_i >= BASE_ADDRESS) && (w_live_idx < ADDR_WIDTH'(DEPTH));
    if (r_state == IDLE) begin
      w_acc_idx      = w_live_idx[c_idx_w-1:0];
      w_acc_in_range = w_live_in_range;
      w_acc_write    = d_m_wren_i;
      w_acc_both     = d_m_rden_i & d_m_wren_i;
      w_acc_wmask    = d_m_wmask_i;
      w_acc_wdata    = d_m_wdata_i;
    end else begin
      w_acc_idx      = r_idx;
      w_acc_in_range = r_in_range;
      w_acc_write    = r_write;
      w_acc_both     = r_both;
      w_acc_wmask    = r_wmask;
      w_acc_wdata    = r_wdata;
    end
    w_go_resp = ((r_state == IDLE) && w_req && (WAIT_STATES == 0)) ||
                ((r_state == WAIT) && (r_cnt == 4'd0));
    w_ram_en  = w_go_resp && w_acc_in_range;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state    <= IDLE;
      r_cnt      <= 4'd0;
      r_idx      <= '0;
      r_in_range <= 1'b0;
      r_write    <= 1'b0;
      r_both     <= 1'b0;
      r_wmask    <= '0;
      r_wdata    <= '0;
      r_hit      <= 1'b0;
      r_oor      <= 1'b0;
      r_from_ram <= 1'b0;
    end else begin
      r_hit <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_idx      <= w_live_idx[c_idx_w-1:0];
            r_in_range <= w_live_in_range;
            r_write    <= d_m_wren_i;
            r_both     <= d_m_rden_i & d_m_wren_i;
            r_wmask    <= d_m_wmask_i;
            r_wdata    <= d_m_wdata_i;
            r_cnt      <= c_cnt_load;
            r_state    <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      // Completion edge: hit rises together with the RAM write / read capture.
      if (w_go_resp) begin
        r_hit <= 1'b1;
        if (!w_acc_in_range) begin
          r_oor <= 1'b1;
        end
        if (w_acc_both) begin
          r_from_ram <= 1'b0;
        end else if (!w_acc_write) begin
          r_from_ram <= w_acc_in_range;
        end
      end
    end
  end

  byte_mask_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk     (clk_i),
    .i_en    (w_ram_en),
    .i_we    (w_acc_write),
    .i_wmask (w_acc_wmask),
    .i_idx   (w_acc_idx),
    .i_wdata (w_acc_wdata),
    .o_rdata (w_ram_rdata)
  );

  assign d_m_rdata_o = r_from_ram ? w_ram_rdata : '0;
  assign d_m_hit_o   = r_hit;
  assign oor_o       = r_oor;
endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Scoreboard bench for a zero- and a two-wait-state responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;
  typedef struct {
    int          hit_cyc;
    logic [31:0] rdata;
    logic        oor;
  } exp_t;

  logic        clk = 1'b0;
  logic        rstn;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  // Index 0: WaitStates=0, Depth=16; index 1: WaitStates=2, Depth=1024.
  logic        rd_s   [2];
  logic        wr_s   [2];
  logic [31:0] addr_s [2];
  logic [3:0]  mask_s [2];
  logic [31:0] wdata_s[2];
  logic [31:0] rdata0, rdata2;
  logic        hit0, hit2, oor0, oor2;

  logic [31:0] mem_m  [2][1024];
  int          depth_m[2] = '{16, 1024};
  int          ws_m   [2] = '{0, 2};
  logic [31:0] last_rd[2];
  logic        oor_m  [2];
  int          last_hit[2];
  int          pend_acc[2];
  exp_t        q0[$];
  exp_t        q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  data_mem_responder #(.DEPTH(16), .WAIT_STATES(0), .BASE_ADDRESS(32'h0)) dut0 (
    .clk_i(clk), .rstn_i(rstn), .d_m_addr_i(addr_s[0]), .d_m_rden_i(rd_s[0]),
    .d_m_wren_i(wr_s[0]), .d_m_wmask_i(mask_s[0]), .d_m_wdata_i(wdata_s[0]),
    .d_m_rdata_o(rdata0), .d_m_hit_o(hit0), .oor_o(oor0));

  data_mem_responder #(.DEPTH(1024), .WAIT_STATES(2), .BASE_ADDRESS(32'h0)) dut2 (
    .clk_i(clk), .rstn_i(rstn), .d_m_addr_i(addr_s[1]), .d_m_rden_i(rd_s[1]),
    .d_m_wren_i(wr_s[1]), .d_m_wmask_i(mask_s[1]), .d_m_wdata_i(wdata_s[1]),
    .d_m_rdata_o(rdata2), .d_m_hit_o(hit2), .oor_o(oor2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic get_hit(input int s);
    return (s == 0) ? hit0 : hit2;
  endfunction

  function automatic logic [31:0] get_rdata(input int s);
    return (s == 0) ? rdata0 : rdata2;
  endfunction

  // Reference model: completion time from the latency rule, data from a word array.
  task automatic issue(input int s, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [3:0] m, input logic [31:0] d);
    exp_t e;
    int   idx;
    bit   inr;
    rd_s[s] = rd; wr_s[s] = wr; addr_s[s] = a; mask_s[s] = m; wdata_s[s] = d;
    pend_acc[s] = (cyc + 1 > last_hit[s] + 2) ? cyc + 1 : last_hit[s] + 2;
    last_hit[s] = pend_acc[s] + ws_m[s];
    idx = int'(a >> 2);
    inr = (a >> 2) < 32'(depth_m[s]);
    if (wr) begin
      if (inr) begin
        for (int b = 0; b < 4; b++) begin
          if (m[b]) mem_m[s][idx][b*8 +: 8] = d[b*8 +: 8];
        end
      end
      if (rd) last_rd[s] = 32'h0;
    end else begin
      last_rd[s] = inr ? mem_m[s][idx] : 32'h0;
    end
    if (!inr) oor_m[s] = 1'b1;
    e.hit_cyc = last_hit[s];
    e.rdata   = last_rd[s];
    e.oor     = oor_m[s];
    if (s == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  // Waits for the hit; once the access is accepted the inputs are scrambled.
  task automatic wait_hit(input int s);
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (get_hit(s)) return;
      if (cyc >= pend_acc[s]) begin
        addr_s[s]  = $urandom;
        wdata_s[s] = $urandom;
        mask_s[s]  = 4'($urandom);
        {rd_s[s], wr_s[s]} = 2'($urandom_range(1, 3));
      end
    end
    chk("hit_timeout", 32'h0, 32'h1);
  endtask

  task automatic idle(input int s);
    rd_s[s] = 1'b0; wr_s[s] = 1'b0;
    @(negedge clk);
    chk("rdata_hold", get_rdata(s), last_rd[s]);
  endtask

  task automatic access(input int s, input bit rd, input bit wr, input logic [31:0] a,
                        input logic [3:0] m, input logic [31:0] d);
    issue(s, rd, wr, a, m, d);
    wait_hit(s);
    idle(s);
  endtask

  task automatic check_hit(input int s, input logic [31:0] rdata, input logic oor);
    exp_t e;
    if ((s == 0 && q0.size() == 0) || (s == 1 && q1.size() == 0)) begin
      chk("unexpected_hit", {31'h0, get_hit(s)}, 32'h0);
    end else begin
      e = (s == 0) ? q0.pop_front() : q1.pop_front();
      chk("hit_cycle", 32'(cyc), 32'(e.hit_cyc));
      chk("hit_rdata", rdata, e.rdata);
      chk("hit_oor", {31'h0, oor}, {31'h0, e.oor});
    end
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (hit0) check_hit(0, rdata0, oor0);
      if (hit2) check_hit(1, rdata2, oor2);
    end
  end

  task automatic reset_model();
    for (int s = 0; s < 2; s++) begin
      last_rd[s] = 32'h0; oor_m[s] = 1'b0; last_hit[s] = -10; pend_acc[s] = 0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    for (int s = 0; s < 2; s++) begin
      rd_s[s] = 0; wr_s[s] = 0; addr_s[s] = 0; mask_s[s] = 0; wdata_s[s] = 0;
    end
    reset_model();
    repeat (3) @(negedge clk);
    chk("rst_hit2", {31'h0, hit2}, 32'h0);
    chk("rst_rdata2", rdata2, 32'h0);
    chk("rst_oor2", {31'h0, oor2}, 32'h0);
    chk("rst_hit0", {31'h0, hit0}, 32'h0);
    rstn = 1'b1;

    for (int w = 0; w < 16; w++) access(1, 0, 1, 32'(w * 4), 4'hF, $urandom);

    access(1, 0, 1, 32'h10, 4'hF, 32'hDEADBEEF);
    access(1, 1, 0, 32'h10, 4'h0, 32'h0);
    access(1, 0, 1, 32'h10, 4'b0001, 32'h000000AA);
    access(1, 1, 0, 32'h10, 4'h0, 32'h0);
    access(1, 0, 1, 32'h14, 4'h0, 32'h55555555);
    access(1, 1, 0, 32'h17, 4'h0, 32'h0);

    issue(1, 1, 0, 32'h0, 4'h0, 32'h0);
    wait_hit(1);
    issue(1, 1, 0, 32'h4, 4'h0, 32'h0);
    wait_hit(1);
    idle(1);

    for (int i = 0; i < 40; i++) begin
      int k;
      logic [31:0] a;
      k = $urandom_range(0, 2);
      a = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      issue(1, k != 1, k != 0, a, 4'($urandom), $urandom);
      wait_hit(1);
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    idle(1);

    access(1, 1, 0, 32'd4096, 4'h0, 32'h0);
    access(1, 0, 1, 32'd8192, 4'hF, 32'h11111111);
    access(1, 1, 0, 32'h10, 4'h0, 32'h0);
    chk("oor_sticky", {31'h0, oor2}, 32'h1);

    rd_s[1] = 0; wr_s[1] = 1; addr_s[1] = 32'h20; mask_s[1] = 4'hF; wdata_s[1] = 32'h12345678;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b0;
    wr_s[1] = 0;
    #1;
    chk("midrst_hit", {31'h0, hit2}, 32'h0);
    chk("midrst_oor", {31'h0, oor2}, 32'h0);
    chk("midrst_rdata", rdata2, 32'h0);
    reset_model();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (6) @(negedge clk);
    chk("no_hit_after_rst", {31'h0, hit2}, 32'h0);
    access(1, 1, 0, 32'h20, 4'h0, 32'h0);

    access(0, 0, 1, 32'hC, 4'hF, 32'hCAFEF00D);
    access(0, 1, 0, 32'hC, 4'h0, 32'h0);
    access(0, 1, 1, 32'hC, 4'hF, 32'h0BADC0DE);
    issue(0, 1, 0, 32'hC, 4'h0, 32'h0);
    wait_hit(0);
    issue(0, 0, 1, 32'h8, 4'b1010, 32'hA5A5A5A5);
    wait_hit(0);
    issue(0, 1, 0, 32'h8, 4'h0, 32'h0);
    wait_hit(0);
    idle(0);
    access(0, 1, 0, 32'd64, 4'h0, 32'h0);

    repeat (3) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'h0);
    chk("q1_drained", 32'(q1.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
